// File: rtl/gbt_chk_pkg.sv
// -----------------------------------------------------------------------------
// gbt_chk_pkg
// Shared types and default constants for the GBT counter-pattern checker.
//   t_chk_state : 2-bit checker FSM state (SEARCH=0, VERIFY=1, LOCKED=2;
//                 encoding 3 is unused and recovers to SEARCH)
//   DEF_*       : default parameter values used by gbt_counter_checker
// -----------------------------------------------------------------------------
package gbt_chk_pkg;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } t_chk_state;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LOCK_CNT   = 8;
    localparam int DEF_UNLOCK_CNT = 4;
    localparam int DEF_ERR_CNT_W  = 16;
    localparam int DEF_LOSS_CNT_W = 8;

endpackage : gbt_chk_pkg

// File: rtl/gbt_sat_counter.sv
// -----------------------------------------------------------------------------
// gbt_sat_counter
// Saturating event counter with synchronous clear.
// Ports:
//   clk_ik  : clock
//   rst_ir  : synchronous active-high reset
//   clear_i : zero the counter (an event in the same cycle loads 1)
//   inc_i   : count one event
//   cnt_ob  : current count, sticks at all-ones
// -----------------------------------------------------------------------------
module gbt_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk_ik,
    input  logic         rst_ir,
    input  logic         clear_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_ob
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            // The event coinciding with the clear is still counted.
            cnt_d = inc_i ? W'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_ob = cnt_q;

endmodule : gbt_sat_counter

// File: rtl/gbt_counter_checker.sv
// -----------------------------------------------------------------------------
// gbt_counter_checker
// Receive-side checker for the GBT incrementing-counter test pattern.
// Seeds on the first valid word, needs LOCK_CNT consecutive matches to lock,
// and flywheels through mismatches while locked, dropping lock after
// UNLOCK_CNT consecutive mismatches.
// Ports:
//   clk_ik, rst_ir      : RX frame clock, synchronous active-high reset
//   valid_i, data_ib    : qualified received pattern word
//   clear_i             : clear counters and first-error snapshot
//   locked_o, error_o   : lock flag, one-cycle pulse per locked mismatch
//   error_cnt_ob        : saturating mismatch count
//   loss_cnt_ob         : saturating LOCKED->SEARCH count
//   state_ob            : FSM state encoding
//   first_err_*         : first-error snapshot (valid, expected, received)
// Optional feature: define GBT_CHK_FIRST_ERR_EN to build the first-error
// snapshot; otherwise the first_err_* outputs are tied to zero.
// -----------------------------------------------------------------------------
module gbt_counter_checker
    import gbt_chk_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LOCK_CNT   = DEF_LOCK_CNT,
    parameter int UNLOCK_CNT = DEF_UNLOCK_CNT,
    parameter int ERR_CNT_W  = DEF_ERR_CNT_W,
    parameter int LOSS_CNT_W = DEF_LOSS_CNT_W
) (
    input  logic                  clk_ik,
    input  logic                  rst_ir,
    input  logic                  valid_i,
    input  logic [DATA_W-1:0]     data_ib,
    input  logic                  clear_i,
    output logic                  locked_o,
    output logic                  error_o,
    output logic [ERR_CNT_W-1:0]  error_cnt_ob,
    output logic [LOSS_CNT_W-1:0] loss_cnt_ob,
    output logic [1:0]            state_ob,
    output logic                  first_err_valid_o,
    output logic [DATA_W-1:0]     first_err_exp_ob,
    output logic [DATA_W-1:0]     first_err_rcv_ob
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int BAD_W  = $clog2(UNLOCK_CNT + 1);

    t_chk_state        state_q, state_d;
    logic [DATA_W-1:0] expected_q, expected_d;
    logic [GOOD_W-1:0] good_run_q, good_run_d;
    logic [BAD_W-1:0]  bad_run_q, bad_run_d;
    logic              error_q;
    logic              err_evt;
    logic              loss_evt;
    logic              match;
    logic [GOOD_W-1:0] good_inc;
    logic [BAD_W-1:0]  bad_inc;

    assign match    = (data_ib == expected_q);
    assign good_inc = good_run_q + GOOD_W'(1);
    assign bad_inc  = bad_run_q + BAD_W'(1);

    always_comb begin
        state_d    = state_q;
        expected_d = expected_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;
        err_evt    = 1'b0;
        loss_evt   = 1'b0;
        case (state_q)
            ST_SEARCH: begin
                if (valid_i) begin
                    expected_d = data_ib + DATA_W'(1);
                    good_run_d = '0;
                    state_d    = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                if (valid_i) begin
                    // Both outcomes track the received word; only the run differs.
                    expected_d = data_ib + DATA_W'(1);
                    if (match) begin
                        if (good_inc == GOOD_W'(LOCK_CNT)) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                            bad_run_d  = '0;
                        end else begin
                            good_run_d = good_inc;
                        end
                    end else begin
                        good_run_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (valid_i) begin
                    if (match) begin
                        bad_run_d  = '0;
                        expected_d = data_ib + DATA_W'(1);
                    end else begin
                        // Flywheel: keep counting locally, never resync on bad data.
                        err_evt    = 1'b1;
                        expected_d = expected_q + DATA_W'(1);
                        if (bad_inc == BAD_W'(UNLOCK_CNT)) begin
                            state_d   = ST_SEARCH;
                            loss_evt  = 1'b1;
                            bad_run_d = '0;
                        end else begin
                            bad_run_d = bad_inc;
                        end
                    end
                end
            end
            default: begin
                state_d    = ST_SEARCH;
                good_run_d = '0;
                bad_run_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            state_q    <= ST_SEARCH;
            expected_q <= '0;
            good_run_q <= '0;
            bad_run_q  <= '0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            expected_q <= expected_d;
            good_run_q <= good_run_d;
            bad_run_q  <= bad_run_d;
            error_q    <= err_evt;
        end
    end

    gbt_sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk_ik  (clk_ik),
        .rst_ir  (rst_ir),
        .clear_i (clear_i),
        .inc_i   (err_evt),
        .cnt_ob  (error_cnt_ob)
    );

    gbt_sat_counter #(.W(LOSS_CNT_W)) u_loss_cnt (
        .clk_ik  (clk_ik),
        .rst_ir  (rst_ir),
        .clear_i (clear_i),
        .inc_i   (loss_evt),
        .cnt_ob  (loss_cnt_ob)
    );

`ifdef GBT_CHK_FIRST_ERR_EN
    logic              first_valid_q;
    logic [DATA_W-1:0] first_exp_q;
    logic [DATA_W-1:0] first_rcv_q;

    always_ff @(posedge clk_ik) begin
        if (rst_ir) begin
            first_valid_q <= 1'b0;
            first_exp_q   <= '0;
            first_rcv_q   <= '0;
        end else if (err_evt && (clear_i || !first_valid_q)) begin
            // A clear coinciding with an error re-arms and captures this error.
            first_valid_q <= 1'b1;
            first_exp_q   <= expected_q;
            first_rcv_q   <= data_ib;
        end else if (clear_i) begin
            first_valid_q <= 1'b0;
            first_exp_q   <= '0;
            first_rcv_q   <= '0;
        end
    end

    assign first_err_valid_o = first_valid_q;
    assign first_err_exp_ob  = first_exp_q;
    assign first_err_rcv_ob  = first_rcv_q;
`else
    assign first_err_valid_o = 1'b0;
    assign first_err_exp_ob  = '0;
    assign first_err_rcv_ob  = '0;
`endif

    assign locked_o = (state_q == ST_LOCKED);
    assign error_o  = error_q;
    assign state_ob = state_q;

endmodule : gbt_counter_checker

// File: tb/tb_gbt_counter_checker.sv
// -----------------------------------------------------------------------------
// tb_gbt_counter_checker
// Scoreboard bench: the driver applies one input set per clock, runs the
// behavioural model and queues the outputs expected after that edge; the
// monitor pops one entry per clock and compares it with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_gbt_counter_checker;

    localparam int DW     = 32;
    localparam int LOCK   = 8;
    localparam int UNLOCK = 4;
    localparam int EW     = 4;
    localparam int LW     = 3;

    logic            clk_ik = 1'b0;
    logic            rst_ir = 1'b1;
    logic            valid_i = 1'b0;
    logic [DW-1:0]   data_ib = '0;
    logic            clear_i = 1'b0;
    logic            locked_o;
    logic            error_o;
    logic [EW-1:0]   error_cnt_ob;
    logic [LW-1:0]   loss_cnt_ob;
    logic [1:0]      state_ob;
    logic            first_err_valid_o;
    logic [DW-1:0]   first_err_exp_ob;
    logic [DW-1:0]   first_err_rcv_ob;

    always #5 clk_ik = ~clk_ik;

    gbt_counter_checker #(
        .DATA_W     (DW),
        .LOCK_CNT   (LOCK),
        .UNLOCK_CNT (UNLOCK),
        .ERR_CNT_W  (EW),
        .LOSS_CNT_W (LW)
    ) dut (
        .clk_ik            (clk_ik),
        .rst_ir            (rst_ir),
        .valid_i           (valid_i),
        .data_ib           (data_ib),
        .clear_i           (clear_i),
        .locked_o          (locked_o),
        .error_o           (error_o),
        .error_cnt_ob      (error_cnt_ob),
        .loss_cnt_ob       (loss_cnt_ob),
        .state_ob          (state_ob),
        .first_err_valid_o (first_err_valid_o),
        .first_err_exp_ob  (first_err_exp_ob),
        .first_err_rcv_ob  (first_err_rcv_ob)
    );

    typedef struct packed {
        logic          locked;
        logic          error;
        logic [EW-1:0] ec;
        logic [LW-1:0] lc;
        logic [1:0]    st;
        logic          fv;
        logic [DW-1:0] fe;
        logic [DW-1:0] fr;
    } obs_t;

    obs_t q[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Reference model: mode 0 = hunting, 1 = confirming, 2 = locked.
    int        m_mode, m_good, m_bad, m_ec, m_lc;
    bit [31:0] m_exp;
    bit        m_fv;
    bit [31:0] m_fe, m_fr;
    bit [31:0] tx;

    task automatic model_reset();
        m_mode = 0; m_good = 0; m_bad = 0; m_ec = 0; m_lc = 0;
        m_exp = 0; m_fv = 0; m_fe = 0; m_fr = 0;
    endtask

    task automatic drive(input bit r, input bit v, input bit c, input bit [31:0] d);
        obs_t      e;
        bit        err;
        bit        loss;
        bit [31:0] prev_exp;
        @(posedge clk_ik);
        #2;
        rst_ir = r; valid_i = v; clear_i = c; data_ib = d;
        err = 0; loss = 0; prev_exp = m_exp;
        if (r) begin
            model_reset();
        end else begin
            if (v) begin
                if (m_mode == 0) begin
                    m_exp = d + 1; m_good = 0; m_mode = 1;
                end else if (m_mode == 1) begin
                    if (d == m_exp) begin
                        m_good++;
                        if (m_good == LOCK) begin
                            m_mode = 2; m_good = 0; m_bad = 0;
                        end
                    end else begin
                        m_good = 0;
                    end
                    m_exp = d + 1;
                end else begin
                    if (d == m_exp) begin
                        m_bad = 0; m_exp = d + 1;
                    end else begin
                        err = 1; m_exp = m_exp + 1; m_bad++;
                        if (m_bad == UNLOCK) begin
                            m_mode = 0; m_bad = 0; loss = 1;
                        end
                    end
                end
            end
            if (c) m_ec = err ? 1 : 0;
            else if (err && m_ec < (1 << EW) - 1) m_ec++;
            if (c) m_lc = loss ? 1 : 0;
            else if (loss && m_lc < (1 << LW) - 1) m_lc++;
`ifdef GBT_CHK_FIRST_ERR_EN
            if (err && (c || !m_fv)) begin
                m_fv = 1; m_fe = prev_exp; m_fr = d;
            end else if (c) begin
                m_fv = 0; m_fe = 0; m_fr = 0;
            end
`endif
        end
        e.locked = (m_mode == 2);
        e.error  = err;
        e.ec     = m_ec[EW-1:0];
        e.lc     = m_lc[LW-1:0];
        e.st     = m_mode[1:0];
        e.fv     = m_fv;
        e.fe     = m_fe;
        e.fr     = m_fr;
        q.push_back(e);
    endtask

    task automatic send_good(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && ($urandom % 3 == 0)) drive(0, 0, 0, $urandom);
            drive(0, 1, 0, tx);
            tx++;
        end
    endtask

    task automatic send_bad(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, tx ^ 32'h8000_0000);
            tx++;
        end
    endtask

    // Monitor: one comparison per clock, sampled 1 time unit after the edge.
    initial begin
        obs_t e;
        obs_t a;
        forever begin
            @(posedge clk_ik);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                a.locked = locked_o;      a.error = error_o;
                a.ec = error_cnt_ob;      a.lc = loss_cnt_ob;
                a.st = state_ob;          a.fv = first_err_valid_o;
                a.fe = first_err_exp_ob;  a.fr = first_err_rcv_ob;
                compared++;
                if (a !== e) begin
                    mismatched++;
                    $display("FAIL txn%0d outputs: got lk=%0b er=%0b ec=%0d lc=%0d st=%0d fv=%0b fe=%h fr=%h, want lk=%0b er=%0b ec=%0d lc=%0d st=%0d fv=%0b fe=%h fr=%h",
                             compared, a.locked, a.error, a.ec, a.lc, a.st, a.fv, a.fe, a.fr,
                             e.locked, e.error, e.ec, e.lc, e.st, e.fv, e.fe, e.fr);
                end else begin
                    $display("txn%0d ok lk=%0b er=%0b ec=%0d lc=%0d st=%0d fv=%0b",
                             compared, a.locked, a.error, a.ec, a.lc, a.st, a.fv);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        model_reset();
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);

        // Lock-in on 100..108, then gapped traffic.
        tx = 100;
        send_good(9, 0);
        send_good(10, 1);

        // Single error while locked.
        drive(1, 0, 0, 0);
        tx = 200;
        send_good(12, 0);
        drive(0, 1, 0, tx); tx++;
        drive(0, 1, 0, 32'hDEAD); tx++;
        drive(0, 1, 0, tx); tx++;
        send_good(3, 0);

        // Loss of lock and re-lock.
        send_bad(UNLOCK);
        send_good(1 + LOCK, 0);
        send_good(3, 1);

        // Wrap with gaps.
        drive(1, 0, 0, 0);
        tx = 32'hFFFF_FFF0;
        send_good(30, 1);

        // Drive both counters into saturation, then clear with an error.
        for (int k = 0; k < 9; k++) begin
            send_bad(UNLOCK);
            send_good(1 + LOCK, 0);
        end
        drive(0, 1, 1, tx ^ 32'h1); tx++;
        send_good(2, 0);
        drive(0, 0, 1, 0);

        // Reset mid-VERIFY and mid-LOCKED.
        send_bad(UNLOCK);
        send_good(4, 0);
        drive(1, 1, 0, tx); tx++;
        send_good(1 + LOCK, 0);
        send_good(2, 0);
        drive(1, 1, 0, tx); tx++;
        send_good(1 + LOCK, 0);

        // Randomized traffic with corruption, clears and rare resets.
        for (int i = 0; i < 400; i++) begin
            bit v, c, r, bad;
            v   = ($urandom % 4) != 0;
            c   = ($urandom % 40) == 0;
            r   = ($urandom % 200) == 0;
            bad = ($urandom % 8) == 0;
            if (v) begin
                drive(r, 1, c, bad ? (tx ^ (32'h1 << $urandom_range(31, 0))) : tx);
                tx++;
            end else begin
                drive(r, 0, c, $urandom);
            end
        end

        wait_cyc = 0;
        while (q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk_ik);
            wait_cyc++;
        end
        #3;
        if (q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule : tb_gbt_counter_checker
